// File: rtl/mem_pkg.sv
// mem_pkg: types and constants shared by the memory request initiator and its command FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

   // A request code of zero means the bus is idle
   localparam logic [7:0] RQST_IDLE = 8'h00;

   // One queued client command
   typedef struct packed {
      logic [7:0]  rqst;
      logic [63:0] addr;
      logic        lock;
   } mem_cmd_t;

   // Initiator handshake phases
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_REL  = 2'd2
   } mem_req_state_e;

   // True when the responder echo acknowledges the outstanding request code
   function automatic logic resp_matches(input logic [7:0] resp, input logic [7:0] rqst);
      return (resp == rqst);
   endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous FIFO of mem_cmd_t, head visible combinationally at rd_dat_o.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push ignored while full_o, pop ignored while empty_o; push+pop together allowed.
module mem_req_fifo
   import mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push_i,
   input  mem_cmd_t wr_dat_i,
   input  logic     pop_i,
   output mem_cmd_t rd_dat_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   mem_cmd_t      mem_q [DEPTH];
   logic          push_ok;
   logic          pop_ok;

   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok  = push_i && !full_o;
   assign pop_ok   = pop_i && !empty_o;
   assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
   end

   // Pointer registers, cleared by reset so the FIFO comes up empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
   end

endmodule

// File: rtl/mem_requester.sv
// mem_requester: queues client commands and issues them one at a time on the m_mem four-phase handshake.
// Latency: accept-to-done 3 cycles against a registering responder; one request per 4 cycles sustained.
// Backpressure: cmd_ready = command FIFO not full. Build option MEM_REQ_TIMEOUT_EN aborts a silent request.
module mem_requester
   import mem_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_rqst,
   input  logic [63:0] cmd_addr,
   input  logic        cmd_lock,
   output logic        done_valid,
   output logic [7:0]  done_trsc,
   output logic [7:0]  done_mesi,
   output logic        done_err,
   output logic        m_mem_lock,
   output logic [7:0]  m_mem_rqst,
   output logic [7:0]  m_mem_trsc,
   output logic [63:0] m_mem_addr,
   input  logic [7:0]  m_mem_resp,
   input  logic [7:0]  m_mem_mesi
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("mem_requester: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   mem_cmd_t       push_dat;
   mem_cmd_t       head_dat;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_pop;
   logic           resp_match;
   logic           rel_done;
   logic           to_hit;

   mem_req_state_e state_q;
   logic [7:0]     rqst_q;
   logic [7:0]     trsc_q;
   logic [63:0]    addr_q;
   logic           lock_q;
   logic [7:0]     trsc_cnt_q;
   logic [7:0]     trsc_cnt_d;
   logic           done_vld_q;
   logic [7:0]     done_trsc_q;
   logic [7:0]     done_mesi_q;
   logic           done_err_q;

   assign push_dat = {cmd_rqst, cmd_addr, cmd_lock};

   mem_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (cmd_valid),
      .wr_dat_i (push_dat),
      .pop_i    (fifo_pop),
      .rd_dat_o (head_dat),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   assign cmd_ready  = !fifo_full;
   assign resp_match = (state_q == ST_REQ) && resp_matches(m_mem_resp, rqst_q);
   assign rel_done   = (state_q == ST_REL) && (m_mem_resp == RQST_IDLE);
   // The head is popped straight into the bus registers, from IDLE or at the end of release
   assign fifo_pop   = !fifo_empty && ((state_q == ST_IDLE) || rel_done);
   assign trsc_cnt_d = trsc_cnt_q + 8'd1;

`ifdef MEM_REQ_TIMEOUT_EN
   localparam int TW_RAW = $clog2(TIMEOUT + 1);
   localparam int TW     = (TW_RAW < 8) ? 8 : TW_RAW;

   logic [TW-1:0] to_cnt_q;

   // Counts cycles spent in REQ; the TIMEOUT-th REQ cycle without a match aborts
   assign to_hit = (state_q == ST_REQ) && !resp_match && (to_cnt_q == TW'(TIMEOUT - 1));

   // Wait counter: cleared as a request is issued, advanced every REQ cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (fifo_pop) begin
         to_cnt_q <= '0;
      end else if (state_q == ST_REQ) begin
         to_cnt_q <= to_cnt_q + TW'(1);
      end
   end
`else
   // Without the timeout option a request waits for its response indefinitely
   assign to_hit = 1'b0;
`endif

   // Request FSM with registered bus and completion outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rqst_q      <= RQST_IDLE;
         trsc_q      <= 8'h00;
         addr_q      <= 64'h0;
         lock_q      <= 1'b0;
         trsc_cnt_q  <= 8'h00;
         done_vld_q  <= 1'b0;
         done_trsc_q <= 8'h00;
         done_mesi_q <= 8'h00;
         done_err_q  <= 1'b0;
      end else begin
         done_vld_q <= 1'b0;
         done_err_q <= 1'b0;
         if (fifo_pop) begin
            // Issue: bus outputs are loaded once and held for the whole REQ phase
            rqst_q  <= head_dat.rqst;
            addr_q  <= head_dat.addr;
            lock_q  <= head_dat.lock;
            trsc_q  <= trsc_cnt_q;
            state_q <= ST_REQ;
         end else if ((state_q == ST_REQ) && (resp_match || to_hit)) begin
            // Completion or abort: report, drop the request and enter release
            done_vld_q  <= 1'b1;
            done_trsc_q <= trsc_q;
            done_mesi_q <= resp_match ? m_mem_mesi : 8'h00;
            done_err_q  <= !resp_match;
            rqst_q      <= RQST_IDLE;
            lock_q      <= 1'b0;
            trsc_cnt_q  <= trsc_cnt_d;
            state_q     <= ST_REL;
         end else if (rel_done) begin
            state_q <= ST_IDLE;
         end else if ((state_q != ST_IDLE) && (state_q != ST_REQ) && (state_q != ST_REL)) begin
            state_q <= ST_IDLE;
         end
      end
   end

   assign m_mem_rqst = rqst_q;
   assign m_mem_trsc = trsc_q;
   assign m_mem_addr = addr_q;
   assign m_mem_lock = lock_q;
   assign done_valid = done_vld_q;
   assign done_trsc  = done_trsc_q;
   assign done_mesi  = done_mesi_q;
   assign done_err   = done_err_q;

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed stimulus against mem_requester with a registering responder model,
// an in-order completion model and a per-cycle compare process.
// Build with MEM_REQ_TIMEOUT_EN defined to also exercise the timeout abort (TIMEOUT=10).
module tb_mem_requester;
   import mem_pkg::*;

`ifdef MEM_REQ_TIMEOUT_EN
   localparam int TO = 10;
`else
   localparam int TO = 255;
`endif

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_rqst;
   logic [63:0] cmd_addr;
   logic        cmd_lock;
   logic        done_valid;
   logic [7:0]  done_trsc;
   logic [7:0]  done_mesi;
   logic        done_err;
   logic        m_mem_lock;
   logic [7:0]  m_mem_rqst;
   logic [7:0]  m_mem_trsc;
   logic [63:0] m_mem_addr;
   logic [7:0]  m_mem_resp;
   logic [7:0]  m_mem_mesi;

   mem_requester #(.DEPTH(4), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_rqst   (cmd_rqst),
      .cmd_addr   (cmd_addr),
      .cmd_lock   (cmd_lock),
      .done_valid (done_valid),
      .done_trsc  (done_trsc),
      .done_mesi  (done_mesi),
      .done_err   (done_err),
      .m_mem_lock (m_mem_lock),
      .m_mem_rqst (m_mem_rqst),
      .m_mem_trsc (m_mem_trsc),
      .m_mem_addr (m_mem_addr),
      .m_mem_resp (m_mem_resp),
      .m_mem_mesi (m_mem_mesi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Responder: 0 = echo rqst one cycle later, 1 = drive force_val, 2 = silent
   int         rsp_mode  = 0;
   logic [7:0] force_val = 8'h00;
   logic [7:0] rsp_mesi  = 8'h01;
   always @(posedge clk or posedge rst) begin
      if (rst) m_mem_resp <= 8'h00;
      else if (rsp_mode == 0) m_mem_resp <= m_mem_rqst;
      else if (rsp_mode == 1) m_mem_resp <= force_val;
      else m_mem_resp <= 8'h00;
   end
   assign m_mem_mesi = rsp_mesi;

   // Model: commands complete in acceptance order; the k-th accepted since reset carries ID k mod 256
   typedef struct {
      logic [7:0]  rqst;
      logic [63:0] addr;
      logic        lock;
      logic [7:0]  trsc;
      bit          to;
   } exp_t;

   exp_t iss_q[$];
   exp_t cpl_q[$];
   exp_t cur;
   exp_t e;
   int   mdl_trsc = 0;
   bit   exp_to   = 1'b0;
   int   done_cnt = 0;
   int   acc_cyc[$];
   int   issue_cyc[$];
   int   done_cyc[$];
   int   trsc_log[$];
   int   mesi_log[$];
   int   err_log[$];
   logic prev_done = 1'b0;
   logic [7:0] prev_rqst = 8'h00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      iss_q.delete();
      cpl_q.delete();
      acc_cyc.delete();
      issue_cyc.delete();
      done_cyc.delete();
      trsc_log.delete();
      mesi_log.delete();
      err_log.delete();
      mdl_trsc  = 0;
      done_cnt  = 0;
      prev_done = 1'b0;
      prev_rqst = 8'h00;
   endtask

   // Compare process: runs every falling edge outside reset
   always @(negedge clk) begin
      if (!rst) begin
         if (m_mem_rqst != 8'h00 && prev_rqst == 8'h00) begin
            check("issue_pending", iss_q.size() != 0, 1);
            if (iss_q.size() != 0) begin
               cur = iss_q.pop_front();
               issue_cyc.push_back(cyc);
            end
         end
         if (m_mem_rqst != 8'h00) begin
            check("bus_rqst", m_mem_rqst, cur.rqst);
            check("bus_addr", m_mem_addr, cur.addr);
            check("bus_lock", m_mem_lock, cur.lock);
            check("bus_trsc", m_mem_trsc, cur.trsc);
         end else begin
            check("bus_lock_idle", m_mem_lock, 0);
         end
         if (done_valid) begin
            check("done_gap", prev_done, 0);
            check("done_pending", cpl_q.size() != 0, 1);
            if (cpl_q.size() != 0) begin
               e = cpl_q.pop_front();
               check("done_trsc", done_trsc, e.trsc);
               check("done_mesi", done_mesi, e.to ? 8'h00 : rsp_mesi);
               check("done_err", done_err, e.to);
            end
            done_cnt++;
            done_cyc.push_back(cyc);
            trsc_log.push_back(int'(done_trsc));
            mesi_log.push_back(int'(done_mesi));
            err_log.push_back(int'(done_err));
         end
         if (cmd_valid && cmd_ready) begin
            e.rqst = cmd_rqst;
            e.addr = cmd_addr;
            e.lock = cmd_lock;
            e.trsc = 8'(mdl_trsc);
            e.to   = exp_to;
            iss_q.push_back(e);
            cpl_q.push_back(e);
            acc_cyc.push_back(cyc + 1);
            mdl_trsc = (mdl_trsc + 1) % 256;
         end
         prev_done = done_valid;
         prev_rqst = m_mem_rqst;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      rsp_mode = 0;
      exp_to = 1'b0;
      repeat (2) @(posedge clk);
      clear_model();
      #1 rst = 1'b0;
   endtask

   // Present one command until accepted; returns 1 in stalled if cmd_ready was low first
   task automatic send(input logic [7:0] r, input logic [63:0] a, input logic l, output bit stalled);
      int n = 0;
      cmd_rqst  = r;
      cmd_addr  = a;
      cmd_lock  = l;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      stalled = (n != 0);
      if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      int k = 0;
      while (done_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_count", done_cnt, n);
   endtask

   initial begin
      bit st;
      int first_stall;
      int k;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_rqst = 8'h00;
      cmd_addr = 64'h0;
      cmd_lock = 1'b0;

      // Reset state
      #2;
      check("rst_rqst", m_mem_rqst, 0);
      check("rst_lock", m_mem_lock, 0);
      check("rst_trsc", m_mem_trsc, 0);
      check("rst_addr", m_mem_addr, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_done_err", done_err, 0);
      check("rst_cmd_ready", cmd_ready, 1);

      // Single command, ground-style responder with mesi=1
      do_reset();
      rsp_mesi = 8'h01;
      send(8'h03, 64'h1000, 1'b0, st);
      wait_done(1, 20);
      repeat (3) @(negedge clk);
      if (issue_cyc.size() >= 1 && done_cyc.size() >= 1) begin
         check("single_issue_lat", issue_cyc[0] - acc_cyc[0], 1);
         check("single_done_lat", done_cyc[0] - acc_cyc[0], 3);
         check("single_trsc", trsc_log[0], 0);
         check("single_mesi", mesi_log[0], 1);
      end
      check("single_idle_rqst", m_mem_rqst, 0);
      check("single_idle_trsc", m_mem_trsc, 0);
      check("single_idle_addr", m_mem_addr, 64'h1000);

      // Burst of 6 into a 4-deep FIFO
      do_reset();
      rsp_mesi = 8'h02;
      first_stall = -1;
      for (int i = 0; i < 6; i++) begin
         send(8'(i + 1), 64'(i * 64), i[0], st);
         if (st && first_stall < 0) first_stall = i;
      end
      wait_done(6, 100);
      check("burst_first_stall", first_stall, 5);
      if (done_cyc.size() >= 6) begin
         check("burst_first_lat", done_cyc[0] - acc_cyc[0], 3);
         for (int i = 0; i < 6; i++) check("burst_trsc", trsc_log[i], i);
         for (int i = 1; i < 6; i++) check("burst_spacing", done_cyc[i] - done_cyc[i - 1], 4);
      end

      // Transaction ID wrap after 256 requests
      do_reset();
      rsp_mesi = 8'h04;
      for (int i = 0; i < 257; i++) send(8'((i % 255) + 1), 64'(i), 1'b0, st);
      wait_done(257, 50);
      if (trsc_log.size() >= 257) begin
         check("wrap_trsc_255", trsc_log[255], 255);
         check("wrap_trsc_256", trsc_log[256], 0);
      end

      // Non-matching response is ignored; match completes; release waits for resp=0
      do_reset();
      rsp_mesi = 8'h03;
      rsp_mode = 1;
      force_val = 8'h07;
      send(8'h03, 64'h2000, 1'b1, st);
      k = 0;
      while (m_mem_rqst == 8'h00 && k < 20) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      check("mismatch_no_done", done_cnt, 0);
      check("mismatch_hold_rqst", m_mem_rqst, 8'h03);
      force_val = 8'h03;
      wait_done(1, 20);
      repeat (3) @(negedge clk);
      check("rel_hold_rqst", m_mem_rqst, 0);
      check("rel_no_extra_done", done_cnt, 1);
      rsp_mode = 0;
      send(8'h05, 64'h2040, 1'b0, st);
      wait_done(2, 20);
      if (trsc_log.size() >= 2) begin
         check("mismatch_trsc0", trsc_log[0], 0);
         check("mismatch_mesi0", mesi_log[0], 3);
         check("after_rel_trsc1", trsc_log[1], 1);
      end

      // Asynchronous reset in the middle of REQ
      do_reset();
      rsp_mode = 2;
      send(8'h03, 64'h3000, 1'b0, st);
      send(8'h04, 64'h3040, 1'b0, st);
      send(8'h05, 64'h3080, 1'b0, st);
      repeat (2) @(negedge clk);
      check("pre_reset_rqst", m_mem_rqst, 8'h03);
      #1 rst = 1'b1;
      #1;
      check("async_rst_rqst", m_mem_rqst, 0);
      check("async_rst_ready", cmd_ready, 1);
      check("async_rst_done", done_valid, 0);
      clear_model();
      @(posedge clk);
      #1 rst = 1'b0;
      rsp_mode = 0;
      rsp_mesi = 8'h01;
      send(8'h09, 64'h4000, 1'b0, st);
      wait_done(1, 20);
      repeat (4) @(negedge clk);
      check("post_rst_done_count", done_cnt, 1);
      if (trsc_log.size() >= 1) check("post_rst_trsc", trsc_log[0], 0);

`ifdef MEM_REQ_TIMEOUT_EN
      // Silent responder: abort after TIMEOUT cycles in REQ, then the next command proceeds
      do_reset();
      rsp_mode = 2;
      exp_to = 1'b1;
      send(8'h03, 64'h5000, 1'b0, st);
      exp_to = 1'b0;
      send(8'h04, 64'h5040, 1'b0, st);
      k = 0;
      while (done_cnt < 1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      rsp_mode = 0;
      wait_done(2, 40);
      if (done_cyc.size() >= 2 && issue_cyc.size() >= 1) begin
         check("timeout_lat", done_cyc[0] - issue_cyc[0], 10);
         check("timeout_err0", err_log[0], 1);
         check("timeout_mesi0", mesi_log[0], 0);
         check("timeout_err1", err_log[1], 0);
         check("timeout_trsc1", trsc_log[1], 1);
      end
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
